fir_tap_accumulator: RTL and testbench
======================================

// Module: fir_tap_accumulator
// PURPOSE
//  Consumes the parallel tap bus of the audio delay line (16-bit samples, 32 taps, packed 512 bits).
//  On each new-sample strobe: snapshot taps, 32-cycle sequential signed MAC against a coefficient bank,
//  round, saturate, present one filtered sample over a valid/ready handshake. Sits between the delay line and the I2S DAC path.
// PARAMETERS
//  WIDTH   16  sample width (signed two's complement)
//  NTAPS   32  number of taps on the tap bus
//  CW      16  coefficient width (signed, Q1.15)
//  ACCW    40  accumulator width (>= WIDTH+CW+clog2(NTAPS))
//  SHIFT   15  output scaling right-shift
// PORTS
//  clock         in   1             single clock; all logic rising-edge
//  aclr          in   1             asynchronous active-high reset
//  sample_valid  in   1             1-cycle strobe: tap bus holds a new delay-line state
//  taps          in   WIDTH*NTAPS   tap k = taps[WIDTH*k +: WIDTH], k=0 newest
//  out_data      out  WIDTH         filtered sample, stable while out_valid
//  out_valid     out  1             result available
//  out_ready     in   1             downstream accepts when out_valid&&out_ready
//  busy          out  1             1 in any state other than IDLE
//  overrun       out  1             1-cycle pulse: sample_valid dropped
//  coef_we/coef_addr[4:0]/coef_wdata[CW-1:0]  in   coefficient write port (COEF_WR_EN only)
// BEHAVIOUR
//  Reset: state=IDLE, out_data=0, out_valid=0, busy=0, overrun=0, acc=0, idx=0; active bank=DEFAULT_COEF.
//  IDLE: sample_valid -> latch taps into snapshot, copy shadow coef bank to active bank, acc=0, idx=0 -> ACCUM.
//  ACCUM: per cycle acc += sext(tap[idx])*sext(coef[idx]); idx++; after idx==NTAPS-1 -> ROUND.
//  ROUND: r = (acc + 2^(SHIFT-1)) >>> SHIFT; saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; load out_data -> OUTPUT.
//  OUTPUT: out_valid=1, out_data held until out_ready. Handshake -> IDLE, out_valid=0 next cycle.
//  Latency: sample_valid at cycle 0 -> out_valid first high at cycle NTAPS+2 (34); throughput 1 sample / 35 cycles with out_ready tied 1.
//  Simultaneous handshake and sample_valid in OUTPUT: sample accepted, go straight to ACCUM (no overrun).
//  sample_valid in ACCUM/ROUND, or in OUTPUT without handshake: sample dropped, overrun pulses 1 cycle; current result unaffected.
//  Taps bus changes after snapshot have no effect on the in-flight result.
//  aclr mid-operation: immediate return to reset values; partial result discarded, no out_valid.
//  Arithmetic: products WIDTH+CW bits signed, accumulator ACCW signed, no intermediate wrap at defaults.
// CONFIGURATION
//  FIR_COEF_WR_EN defined: coef_we/addr/wdata present; write updates shadow bank entry coef_addr in the
//   same cycle, any state; shadow copied to active bank only on IDLE->ACCUM (and OUTPUT->ACCUM), so a
//   result never mixes old and new coefficients. Write and start on same cycle: new value used.
//  FIR_COEF_WR_EN undefined: ports absent; active bank is constant DEFAULT_COEF, no shadow registers.
// STRUCTURE
//  Package audio_fir_pkg: WIDTH/NTAPS/CW/ACCW/SHIFT constants, DEFAULT_COEF array (all 1024 = 1/32
//   moving average), state enum {IDLE, ACCUM, ROUND, OUTPUT}, sat_round() function.
//  Sub-module fir_mac_unit: signed multiply, accumulate, clear, round/saturate; top holds FSM, snapshot, coef banks.
// TESTING
//  1 Default coefs, all taps=1000, sample_valid pulse -> out_valid at cycle 34, out_data=1000; busy high cycles 1..34.
//  2 All taps=32767, all coefs=32767 (COEF_WR_EN) -> out_data=32767; taps=-32768 -> out_data=-32768 (saturation).
//  3 coef[0]=32767 others 0, tap0=1000 others 5000 -> out_data=1000; tap0=-1 -> out_data=-1 (rounding/sign).
//  4 out_ready=0 for 10 cycles after out_valid; second sample_valid meanwhile -> overrun pulse, out_data unchanged;
//    then out_ready=1 with sample_valid same cycle -> accepted, next result at +34.
//  5 Write coef[3]=0 during ACCUM of sample A -> A uses old coef; sample B uses new coef.
//  6 aclr asserted at cycle 20 of ACCUM -> all outputs 0 immediately, no out_valid; next sample processes normally.

Source files
------------

// File: rtl/fir_tap_accumulator_pkg.sv
// Shared constants, types and the round/saturate helper for the audio FIR tap accumulator.
package audio_fir_pkg;
    localparam int WIDTH = 16;
    localparam int NTAPS = 32;
    localparam int CW    = 16;
    localparam int ACCW  = 40;
    localparam int SHIFT = 15;
    localparam int IDXW  = $clog2(NTAPS);

    typedef logic signed [CW-1:0]    coef_t;
    typedef logic signed [WIDTH-1:0] sample_t;
    typedef logic signed [ACCW-1:0]  acc_t;

    typedef enum logic [1:0] {IDLE, ACCUM, ROUND, OUTPUT} state_t;

    // 1/32 moving average in Q1.15
    localparam coef_t DEFAULT_COEF [NTAPS] = '{default: 16'sd1024};

    localparam logic signed [ACCW:0] RND  = (ACCW+1)'(64'sd1 <<< (SHIFT-1));
    localparam logic signed [ACCW:0] OMAX = (ACCW+1)'((64'sd1 <<< (WIDTH-1)) - 64'sd1);
    localparam logic signed [ACCW:0] OMIN = (ACCW+1)'(-(64'sd1 <<< (WIDTH-1)));
    localparam sample_t SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam sample_t SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    // One guard bit keeps the rounding add from wrapping near the accumulator limits.
    function automatic sample_t sat_round(input acc_t acc);
        logic signed [ACCW:0] t;
        t = (ACCW+1)'(acc) + RND;
        t = t >>> SHIFT;
        if (t > OMAX)      return SMAX;
        else if (t < OMIN) return SMIN;
        else               return t[WIDTH-1:0];
    endfunction
endpackage

// File: rtl/fir_tap_accumulator_mac.sv
// Sequential signed multiply-accumulate with synchronous clear and round/saturate output.
module fir_mac_unit
    import audio_fir_pkg::*;
(
    input  logic    i_clk,
    input  logic    i_rst,
    input  logic    i_clr,
    input  logic    i_en,
    input  sample_t i_tap,
    input  coef_t   i_coef,
    output sample_t o_result
);
    logic signed [WIDTH+CW-1:0] w_prod;
    acc_t                       r_acc;

    assign w_prod = i_tap * i_coef;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)      r_acc <= '0;
        else if (i_clr) r_acc <= '0;
        else if (i_en)  r_acc <= r_acc + ACCW'(w_prod);
    end

    assign o_result = sat_round(r_acc);
endmodule

// File: rtl/fir_tap_accumulator.sv
// FIR tap accumulator: snapshot tap bus, 32-cycle MAC, round/saturate, valid/ready output.
// Define FIR_COEF_WR_EN to add the runtime coefficient write port with shadow/active banks.
module fir_tap_accumulator
    import audio_fir_pkg::*;
(
    input  logic                   clock,
    input  logic                   aclr,
    input  logic                   sample_valid,
    input  logic [WIDTH*NTAPS-1:0] taps,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   overrun
`ifdef FIR_COEF_WR_EN
    ,
    input  logic                   coef_we,
    input  logic [IDXW-1:0]        coef_addr,
    input  logic [CW-1:0]          coef_wdata
`endif
);
    state_t           r_state, w_state_nx;
    logic [IDXW-1:0]  r_idx;
    sample_t          r_snap [NTAPS];
    sample_t          r_out_data;
    logic             r_overrun;
    logic             w_hs, w_start, w_drop;
    coef_t            w_coef;
    sample_t          w_result;

    assign w_hs    = (r_state == OUTPUT) && out_ready;
    assign w_start = sample_valid && ((r_state == IDLE) || w_hs);
    assign w_drop  = sample_valid && !w_start;

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) r_state <= IDLE;
        else      r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_nx = ACCUM;
            ACCUM:   if (r_idx == IDXW'(NTAPS-1)) w_state_nx = ROUND;
            ROUND:   w_state_nx = OUTPUT;
            OUTPUT:  if (w_start) w_state_nx = ACCUM;
                     else if (out_ready) w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            r_idx      <= '0;
            r_out_data <= '0;
            r_overrun  <= 1'b0;
            for (int k = 0; k < NTAPS; k++) r_snap[k] <= '0;
        end else begin
            r_overrun <= w_drop;
            if (w_start) begin
                r_idx <= '0;
                for (int k = 0; k < NTAPS; k++) r_snap[k] <= taps[WIDTH*k +: WIDTH];
            end else if (r_state == ACCUM) begin
                r_idx <= r_idx + 1'b1;
            end
            if (r_state == ROUND) r_out_data <= w_result;
        end
    end

`ifdef FIR_COEF_WR_EN
    coef_t r_coef_sh  [NTAPS];
    coef_t r_coef_act [NTAPS];

    // A write landing on the start cycle is forwarded into the active bank.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            for (int k = 0; k < NTAPS; k++) begin
                r_coef_sh[k]  <= DEFAULT_COEF[k];
                r_coef_act[k] <= DEFAULT_COEF[k];
            end
        end else begin
            if (coef_we) r_coef_sh[coef_addr] <= coef_wdata;
            if (w_start) begin
                for (int k = 0; k < NTAPS; k++)
                    r_coef_act[k] <= (coef_we && coef_addr == IDXW'(k)) ? coef_wdata : r_coef_sh[k];
            end
        end
    end

    assign w_coef = r_coef_act[r_idx];
`else
    assign w_coef = DEFAULT_COEF[r_idx];
`endif

    fir_mac_unit u_mac (
        .i_clk    (clock),
        .i_rst    (aclr),
        .i_clr    (w_start),
        .i_en     (r_state == ACCUM),
        .i_tap    (r_snap[r_idx]),
        .i_coef   (w_coef),
        .o_result (w_result)
    );

    assign out_data  = r_out_data;
    assign out_valid = (r_state == OUTPUT);
    assign busy      = (r_state != IDLE);
    assign overrun   = r_overrun;
endmodule

// File: tb/tb_fir_tap_accumulator.sv
// Directed self-checking bench for fir_tap_accumulator; coefficient-port cases need FIR_COEF_WR_EN.
module tb_fir_tap_accumulator;
    import audio_fir_pkg::*;

    logic                   clock = 1'b0;
    logic                   aclr;
    logic                   sample_valid;
    logic [WIDTH*NTAPS-1:0] taps;
    logic [WIDTH-1:0]       out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic                   busy;
    logic                   overrun;
`ifdef FIR_COEF_WR_EN
    logic                   coef_we;
    logic [IDXW-1:0]        coef_addr;
    logic [CW-1:0]          coef_wdata;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int lat;

    always #5 clock = ~clock;

    fir_tap_accumulator dut (
        .clock        (clock),
        .aclr         (aclr),
        .sample_valid (sample_valid),
        .taps         (taps),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .overrun      (overrun)
`ifdef FIR_COEF_WR_EN
        ,
        .coef_we      (coef_we),
        .coef_addr    (coef_addr),
        .coef_wdata   (coef_wdata)
`endif
    );

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH*NTAPS-1:0] all_taps(input int v);
        logic [WIDTH*NTAPS-1:0] r;
        for (int k = 0; k < NTAPS; k++) r[WIDTH*k +: WIDTH] = WIDTH'(v);
        return r;
    endfunction

    function automatic logic [WIDTH*NTAPS-1:0] tap0_rest(input int v0, input int vr);
        logic [WIDTH*NTAPS-1:0] r;
        r = all_taps(vr);
        r[WIDTH-1:0] = WIDTH'(v0);
        return r;
    endfunction

    // Entered at a negedge; returns at the negedge of cycle 1 (first ACCUM cycle).
    task automatic start(input logic [WIDTH*NTAPS-1:0] v);
        sample_valid = 1'b1;
        taps = v;
        @(negedge clock);
        sample_valid = 1'b0;
    endtask

    // Counts cycles from c0 until out_valid; also counts cycles where busy was low.
    task automatic wait_valid(input int c0, output int l, output int busy_lo);
        l = c0;
        busy_lo = 0;
        while (out_valid !== 1'b1 && l < 200) begin
            if (busy !== 1'b1) busy_lo++;
            @(negedge clock);
            l++;
        end
        if (busy !== 1'b1) busy_lo++;
    endtask

    task automatic accept(input string tag);
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        chk({tag, " valid_drop"}, out_valid, 0);
    endtask

    task automatic run(input string tag, input logic [WIDTH*NTAPS-1:0] v, input int exp);
        int bl;
        start(v);
        wait_valid(1, lat, bl);
        chk({tag, " latency"}, lat, 34);
        chk({tag, " data"}, $signed(out_data), exp);
        accept(tag);
    endtask

`ifdef FIR_COEF_WR_EN
    task automatic wr_coef(input int a, input int v);
        coef_we = 1'b1;
        coef_addr = IDXW'(a);
        coef_wdata = CW'(v);
        @(negedge clock);
        coef_we = 1'b0;
    endtask
`endif

    initial begin
        int bl;
        aclr = 1'b1;
        sample_valid = 1'b0;
        taps = '0;
        out_ready = 1'b0;
`ifdef FIR_COEF_WR_EN
        coef_we = 1'b0;
        coef_addr = '0;
        coef_wdata = '0;
`endif
        repeat (2) @(negedge clock);
        chk("rst out_data", out_data, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst busy", busy, 0);
        chk("rst overrun", overrun, 0);
        aclr = 1'b0;
        @(negedge clock);

        // Default coefs: moving average of constant taps
        start(all_taps(1000));
        chk("t1 busy_c1", busy, 1);
        wait_valid(1, lat, bl);
        chk("t1 latency", lat, 34);
        chk("t1 busy_low", bl, 0);
        chk("t1 data", $signed(out_data), 1000);
        accept("t1");
        chk("t1 busy_idle", busy, 0);

        // Snapshot must ignore bus changes after the start strobe
        start(tap0_rest(0, 0) | {16'd3100, 16'd3000, 16'd2900, 16'd2800, 16'd2700, 16'd2600, 16'd2500, 16'd2400,
                                  16'd2300, 16'd2200, 16'd2100, 16'd2000, 16'd1900, 16'd1800, 16'd1700, 16'd1600,
                                  16'd1500, 16'd1400, 16'd1300, 16'd1200, 16'd1100, 16'd1000, 16'd900,  16'd800,
                                  16'd700,  16'd600,  16'd500,  16'd400,  16'd300,  16'd200,  16'd100,  16'd0});
        taps = all_taps(-5000);
        wait_valid(1, lat, bl);
        chk("ramp latency", lat, 34);
        chk("ramp data", $signed(out_data), 1550);
        accept("ramp");

        run("neg", all_taps(-1000), -1000);
        run("rnd_up", tap0_rest(16, 0), 1);
        run("rnd_dn", tap0_rest(15, 0), 0);
        run("rnd_neg_half", tap0_rest(-16, 0), 0);
        run("rnd_neg", tap0_rest(-17, 0), -1);

        // Overrun during ACCUM leaves the in-flight result intact
        start(all_taps(500));
        repeat (5) @(negedge clock);
        sample_valid = 1'b1;
        taps = all_taps(7000);
        @(negedge clock);
        sample_valid = 1'b0;
        chk("ovr_accum pulse", overrun, 1);
        @(negedge clock);
        chk("ovr_accum end", overrun, 0);
        wait_valid(8, lat, bl);
        chk("ovr_accum latency", lat, 34);
        chk("ovr_accum data", $signed(out_data), 500);
        accept("ovr_accum");

        // Back-pressure in OUTPUT, then handshake with a simultaneous start
        start(all_taps(1000));
        wait_valid(1, lat, bl);
        chk("bp latency", lat, 34);
        repeat (3) @(negedge clock);
        sample_valid = 1'b1;
        taps = all_taps(2000);
        @(negedge clock);
        sample_valid = 1'b0;
        chk("bp overrun", overrun, 1);
        chk("bp valid_held", out_valid, 1);
        chk("bp data_held", $signed(out_data), 1000);
        @(negedge clock);
        chk("bp overrun_end", overrun, 0);
        repeat (5) @(negedge clock);
        chk("bp data_still", $signed(out_data), 1000);
        out_ready = 1'b1;
        sample_valid = 1'b1;
        taps = all_taps(2000);
        @(negedge clock);
        out_ready = 1'b0;
        sample_valid = 1'b0;
        chk("bp hs_valid", out_valid, 0);
        chk("bp hs_busy", busy, 1);
        chk("bp hs_overrun", overrun, 0);
        wait_valid(1, lat, bl);
        chk("bp next_latency", lat, 34);
        chk("bp next_data", $signed(out_data), 2000);
        accept("bp");

        // Asynchronous clear mid-ACCUM
        start(all_taps(1000));
        repeat (19) @(negedge clock);
        aclr = 1'b1;
        #1;
        chk("aclr busy", busy, 0);
        chk("aclr out_data", out_data, 0);
        chk("aclr out_valid", out_valid, 0);
        repeat (3) @(negedge clock);
        aclr = 1'b0;
        repeat (40) @(negedge clock);
        chk("aclr no_valid", out_valid, 0);
        run("post_aclr", all_taps(3000), 3000);

`ifdef FIR_COEF_WR_EN
        for (int k = 0; k < NTAPS; k++) wr_coef(k, 32767);
        run("sat_pos", all_taps(32767), 32767);
        run("sat_neg", all_taps(-32768), -32768);

        for (int k = 1; k < NTAPS; k++) wr_coef(k, 0);
        run("c0_pos", tap0_rest(1000, 5000), 1000);
        run("c0_neg", tap0_rest(-1, 5000), -1);

        for (int k = 0; k < NTAPS; k++) wr_coef(k, 1024);
        start(all_taps(1000));
        wr_coef(3, 0);
        wait_valid(2, lat, bl);
        chk("shadow A latency", lat, 34);
        chk("shadow A data", $signed(out_data), 1000);
        accept("shadow A");
        run("shadow B", all_taps(1000), 969);

        coef_we = 1'b1;
        coef_addr = IDXW'(3);
        coef_wdata = CW'(1024);
        sample_valid = 1'b1;
        taps = all_taps(1000);
        @(negedge clock);
        coef_we = 1'b0;
        sample_valid = 1'b0;
        wait_valid(1, lat, bl);
        chk("wr_start latency", lat, 34);
        chk("wr_start data", $signed(out_data), 1000);
        accept("wr_start");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
